display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 149 ++++++++++++++
 tb/tb_display_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: two-requester (operand entry, result) arbiter feeding a
// single display driver over a valid/ready link, with optional periodic
// re-send of the last value shown.
module display_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_ent_data,
  input  logic                  i_ent_is_neg,
  input  logic                  i_ent_valid,
  output logic                  o_ent_ready,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  input  logic                  i_res_is_neg,
  input  logic                  i_res_valid,
  output logic                  o_res_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_is_neg,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam bit          REFRESH_EN = (REFRESH_CYCLES > 0);
  localparam int          CW         = REFRESH_EN ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = REFRESH_EN ? CW'(REFRESH_CYCLES - 1) : '0;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic [DATA_WIDTH-1:0] ent_data_q, ent_data_d, res_data_q, res_data_d;
  logic                  ent_neg_q, ent_neg_d, res_neg_q, res_neg_d;
  logic                  ent_pend_q, ent_pend_d, res_pend_q, res_pend_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, last_data_q, last_data_d;
  logic                  out_neg_q, out_neg_d, last_neg_q, last_neg_d;
  logic                  shown_q, shown_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fav_res_q, fav_res_d;
  logic                  gnt_ent, gnt_res;
  logic                  ent_xfer, res_xfer;

  // Requesters are always ready once out of reset, so valid alone is a transfer.
  assign o_ent_ready   = rdy_q;
  assign o_res_ready   = rdy_q;
  assign ent_xfer      = i_ent_valid & rdy_q;
  assign res_xfer      = i_res_valid & rdy_q;
  assign o_valid       = (state_q == SEND);
  assign o_data        = out_data_q;
  assign o_data_is_neg = out_neg_q;

  // Slot update: a new write always wins; a grant clears pending unless
  // the same cycle brings a fresh value (which then stays pending).
  always_comb begin
    ent_data_d = ent_xfer ? i_ent_data   : ent_data_q;
    ent_neg_d  = ent_xfer ? i_ent_is_neg : ent_neg_q;
    ent_pend_d = ent_xfer | (ent_pend_q & ~gnt_ent);
    res_data_d = res_xfer ? i_res_data   : res_data_q;
    res_neg_d  = res_xfer ? i_res_is_neg : res_neg_q;
    res_pend_d = res_xfer | (res_pend_q & ~gnt_res);
  end

  // Arbitration / send FSM with refresh. The round-robin pointer only moves
  // on a real tie, so a lone request does not steal the next tie's turn.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_neg_d   = out_neg_q;
    last_data_d = last_data_q;
    last_neg_d  = last_neg_q;
    shown_d     = shown_q;
    cnt_d       = cnt_q;
    fav_res_d   = fav_res_q;
    gnt_ent     = 1'b0;
    gnt_res     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ent_pend_q || res_pend_q) begin
          if (ent_pend_q && res_pend_q) begin
            gnt_res   = fav_res_q;
            gnt_ent   = ~fav_res_q;
            fav_res_d = ~fav_res_q;
          end else begin
            gnt_ent = ent_pend_q;
            gnt_res = res_pend_q;
          end
          out_data_d = gnt_res ? res_data_q : ent_data_q;
          out_neg_d  = gnt_res ? res_neg_q  : ent_neg_q;
          state_d    = SEND;
        end else begin
          if (REFRESH_EN && shown_q && (cnt_q == CNT_MAX)) begin
            out_data_d = last_data_q;
            out_neg_d  = last_neg_q;
            state_d    = SEND;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (i_ready) begin
          last_data_d = out_data_q;
          last_neg_d  = out_neg_q;
          shown_d     = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight value and refresh history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      ent_data_q  <= '0;
      ent_neg_q   <= 1'b0;
      ent_pend_q  <= 1'b0;
      res_data_q  <= '0;
      res_neg_q   <= 1'b0;
      res_pend_q  <= 1'b0;
      out_data_q  <= '0;
      out_neg_q   <= 1'b0;
      last_data_q <= '0;
      last_neg_q  <= 1'b0;
      shown_q     <= 1'b0;
      cnt_q       <= '0;
      fav_res_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      ent_data_q  <= ent_data_d;
      ent_neg_q   <= ent_neg_d;
      ent_pend_q  <= ent_pend_d;
      res_data_q  <= res_data_d;
      res_neg_q   <= res_neg_d;
      res_pend_q  <= res_pend_d;
      out_data_q  <= out_data_d;
      out_neg_q   <= out_neg_d;
      last_data_q <= last_data_d;
      last_neg_q  <= last_neg_d;
      shown_q     <= shown_d;
      cnt_q       <= cnt_d;
      fav_res_q   <= fav_res_d;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: cycle-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_display_arbiter;
  localparam int DW = 16;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_ent_data = '0, i_res_data = '0;
  logic          i_ent_is_neg = 1'b0, i_ent_valid = 1'b0;
  logic          i_res_is_neg = 1'b0, i_res_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_ent_ready, o_res_ready, o_data_is_neg, o_valid;
  logic [DW-1:0] o_data;

  display_arbiter #(.DATA_WIDTH(DW), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ent_data(i_ent_data), .i_ent_is_neg(i_ent_is_neg), .i_ent_valid(i_ent_valid),
    .o_ent_ready(o_ent_ready),
    .i_res_data(i_res_data), .i_res_is_neg(i_res_is_neg), .i_res_valid(i_res_valid),
    .o_res_ready(o_res_ready),
    .o_data(o_data), .o_data_is_neg(o_data_is_neg), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit saw2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a "busy" display link, two latest-value mailboxes,
  // a tie-break preference, and a count of quiet idle cycles since the
  // last completed display transfer.
  bit          m_busy, m_rdy, m_favres, m_shown, m_pe, m_pr;
  logic [DW:0] m_out, m_last, m_ent, m_res;   // {sign, magnitude}
  int          m_idle;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_rdy = 0; m_favres = 1; m_shown = 0; m_pe = 0; m_pr = 0;
      m_out = '0; m_last = '0; m_ent = '0; m_res = '0; m_idle = 0;
    end else begin
      bit ex, rx, take_res;
      ex = i_ent_valid && m_rdy;
      rx = i_res_valid && m_rdy;
      if (!m_busy) begin
        if (m_pe || m_pr) begin
          take_res = m_pr && (!m_pe || m_favres);
          if (m_pe && m_pr) m_favres = !take_res;
          if (take_res) begin m_out = m_res; m_pr = 0; end
          else begin m_out = m_ent; m_pe = 0; end
          m_busy = 1;
        end else begin
          if (m_shown && (m_idle + 1 >= RC)) begin m_out = m_last; m_busy = 1; end
          m_idle++;
        end
      end else if (i_ready) begin
        m_last = m_out; m_shown = 1; m_idle = 0; m_busy = 0;
      end
      if (ex) begin m_ent = {i_ent_is_neg, i_ent_data}; m_pe = 1; end
      if (rx) begin m_res = {i_res_is_neg, i_res_data}; m_pr = 1; end
      m_rdy = 1;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("ent_ready", o_ent_ready, m_rdy);
      chk("res_ready", o_res_ready, m_rdy);
      chk("valid", o_valid, m_busy);
      if (o_valid && m_busy) chk("data", {o_data_is_neg, o_data}, m_out);
      if (o_valid && o_data == 16'h0002) saw2 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ent(input logic [DW-1:0] d, input logic n);
    i_ent_data = d; i_ent_is_neg = n; i_ent_valid = 1'b1;
  endtask

  task automatic res(input logic [DW-1:0] d, input logic n);
    i_res_data = d; i_res_is_neg = n; i_res_valid = 1'b1;
  endtask

  task automatic drop();
    i_ent_valid = 1'b0; i_res_valid = 1'b0;
  endtask

  initial begin
    int highs, n;
    repeat (3) @(posedge clk);
    chk("rst_ready_low", o_ent_ready, 0);
    #1 rst_n = 1'b1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", {o_data_is_neg, o_data}, 0);
    tick();
    chk("ready_after_rel", {o_ent_ready, o_res_ready}, 2'b11);

    // Cold start: no refresh without a prior transfer.
    highs = 0;
    repeat (30) begin tick(); highs += int'(o_valid); end
    chk("cold_no_refresh", highs, 0);

    // Single entry, one-cycle pulse.
    i_ready = 1'b1; ent(16'h1234, 0); tick(); drop();
    chk("lat_pending", o_valid, 0);
    tick();
    chk("single_valid", o_valid, 1);
    chk("single_data", {o_data_is_neg, o_data}, 17'h01234);
    tick();
    chk("single_drop", o_valid, 0);

    // Latest-wins while the link is stalled.
    i_ready = 1'b0;
    ent(16'h0001, 0); tick();
    ent(16'h0002, 0); tick();
    chk("stall_first", {o_valid, o_data}, 17'h10001);
    ent(16'h0003, 0); tick(); drop();
    repeat (3) tick();
    chk("stall_hold", {o_valid, o_data}, 17'h10001);
    i_ready = 1'b1; tick();
    chk("stall_gap", o_valid, 0);
    tick();
    chk("stall_latest", {o_valid, o_data}, 17'h10003);
    tick();

    // Refresh cadence.
    ent(16'h0042, 0); tick(); drop(); tick();
    chk("r_send", {o_valid, o_data}, 17'h10042);
    tick();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!o_valid && n < 20) begin tick(); n++; end
      chk("refresh_gap", n, RC);
      chk("refresh_data", {o_valid, o_data_is_neg, o_data}, 18'h20042);
      tick();
    end

    // Reset asserted mid-send.
    i_ready = 1'b0; ent(16'h0777, 0); tick(); drop(); tick();
    chk("pre_reset_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_ready", {o_ent_ready, o_res_ready}, 0);
    chk("async_data", o_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; i_ready = 1'b1;
    highs = 0;
    repeat (20) begin tick(); highs += int'(o_valid); end
    chk("post_reset_quiet", highs, 0);

    // Tie after reset goes to result; next tie to entry.
    ent(16'h0005, 0); res(16'h00FF, 1); tick(); drop(); tick();
    chk("tie1", {o_valid, o_data_is_neg, o_data}, 18'h300FF);
    tick();
    chk("tie1_gap", o_valid, 0);
    tick();
    chk("tie1_second", {o_valid, o_data_is_neg, o_data}, 18'h20005);
    tick();
    ent(16'h0AAA, 0); res(16'h0BBB, 0); tick(); drop(); tick();
    chk("tie2", {o_valid, o_data}, 17'h10AAA);
    tick(); tick();
    chk("tie2_second", {o_valid, o_data}, 17'h10BBB);
    tick();

    // Mixed traffic with a stalling driver, checked by the model.
    for (int k = 0; k < 300; k++) begin
      i_ready      = ($urandom_range(0, 2) != 0);
      i_ent_valid  = ($urandom_range(0, 4) == 0);
      i_ent_data   = DW'($urandom) | 16'h0100;
      i_ent_is_neg = $urandom_range(0, 1) == 1;
      i_res_valid  = ($urandom_range(0, 4) == 0);
      i_res_data   = DW'($urandom) | 16'h0100;
      i_res_is_neg = $urandom_range(0, 1) == 1;
      tick();
    end
    drop(); i_ready = 1'b1;
    repeat (30) tick();

    chk("never_0002", saw2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
